// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer family.
//   DIR_UP / DIR_DN     : values of the up_dn direction input
//   MODE_WRAP / MODE_SAT: values of the SATURATE limit-mode parameter
//   clamp_load()        : limits a parallel-load value to the count range
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // 32-bit operands so any counter width up to 32 can share one helper;
  // callers size the result back down to their own width.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_limit_detect.sv
// Combinational limit compare for a counter with range 0..MAX_VAL.
//   count   : current count value
//   at_max  : count == MAX_VAL
//   at_zero : count == 0
module counter_limit_detect #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  always_comb begin
    at_max  = (count == MAX_W);
    at_zero = (count == '0);
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with synchronous load, wrap or saturate
// limit handling, terminal-count flag and registered limit event pulse.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (count=0, evt=0)
//   en       : count enable, one step per cycle
//   up_dn    : 1 = increment, 0 = decrement
//   load     : parallel load strobe (priority over en)
//   load_val : value to load, clamped to MAX_VAL
//   count    : registered count, range 0..MAX_VAL
//   tc       : en & (up_dn ? count==MAX_VAL : count==0), combinational
//   evt      : one-cycle pulse alongside the count produced by a limit step
module updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int          SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] count_nxt;
  logic             evt_nxt;
  logic [WIDTH-1:0] load_clamped;

  counter_limit_detect #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_limit (
    .count   (count),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));

  // Limits are detected by explicit compare, so a non-power-of-two
  // MAX_VAL wraps at MAX_VAL rather than at 2**WIDTH.
  always_comb begin
    count_nxt = count;
    evt_nxt   = 1'b0;
    if (load) begin
      count_nxt = load_clamped;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          evt_nxt = 1'b1;
          if (!SAT_MODE) count_nxt = '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          evt_nxt = 1'b1;
          if (!SAT_MODE) count_nxt = MAX_W;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      evt   <= 1'b0;
    end else begin
      count <= count_nxt;
      evt   <= evt_nxt;
    end
  end

  assign tc = en & ((up_dn == DIR_UP) ? at_max : at_zero);

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- wrap instance: WIDTH=4, MAX_VAL=9 ----------------
  logic       w_rst = 1'b1, w_en = 1'b0, w_up = 1'b1, w_load = 1'b0;
  logic [3:0] w_lval = '0;
  logic [3:0] w_count;
  logic       w_tc, w_evt;

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_w (
    .clk(clk), .rst(w_rst), .en(w_en), .up_dn(w_up), .load(w_load),
    .load_val(w_lval), .count(w_count), .tc(w_tc), .evt(w_evt)
  );

  // ---------------- saturate instance: WIDTH=4, MAX_VAL=9 ------------
  logic       s_rst = 1'b1, s_en = 1'b0, s_up = 1'b1, s_load = 1'b0;
  logic [3:0] s_lval = '0;
  logic [3:0] s_count;
  logic       s_tc, s_evt;

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_s (
    .clk(clk), .rst(s_rst), .en(s_en), .up_dn(s_up), .load(s_load),
    .load_val(s_lval), .count(s_count), .tc(s_tc), .evt(s_evt)
  );

  // ---------------- cascade: two 8-bit stages, tc -> en --------------
  logic       c_rst = 1'b1;
  logic [7:0] lo_count, hi_count;
  logic       lo_tc, lo_evt, hi_tc, hi_evt;

  updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) dut_lo (
    .clk(clk), .rst(c_rst), .en(1'b1), .up_dn(1'b1), .load(1'b0),
    .load_val(8'd0), .count(lo_count), .tc(lo_tc), .evt(lo_evt)
  );

  updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0)) dut_hi (
    .clk(clk), .rst(c_rst), .en(lo_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(8'd0), .count(hi_count), .tc(hi_tc), .evt(hi_evt)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_count;
    logic       exp_evt;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lv, input logic [3:0] c,
                     input logic ev, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
    v.exp_count = c; v.exp_evt = ev; v.exp_tc = t;
    vecs.push_back(v);
  endtask

  initial begin
    // rst en up load lval | count evt tc   (tc evaluated with the same inputs held)
    add(1, 0, 1, 0,  0,    0, 0, 0);   // reset
    add(0, 1, 1, 0,  0,    1, 0, 0);   // count up 1..9, wrap, 1, 2
    add(0, 1, 1, 0,  0,    2, 0, 0);
    add(0, 1, 1, 0,  0,    3, 0, 0);
    add(0, 1, 1, 0,  0,    4, 0, 0);
    add(0, 1, 1, 0,  0,    5, 0, 0);
    add(0, 1, 1, 0,  0,    6, 0, 0);
    add(0, 1, 1, 0,  0,    7, 0, 0);
    add(0, 1, 1, 0,  0,    8, 0, 0);
    add(0, 1, 1, 0,  0,    9, 0, 1);
    add(0, 1, 1, 0,  0,    0, 1, 0);
    add(0, 1, 1, 0,  0,    1, 0, 0);
    add(0, 1, 1, 0,  0,    2, 0, 0);
    add(1, 1, 0, 0,  0,    0, 0, 1);   // reset beats en; tc for down at 0
    add(0, 1, 0, 0,  0,    9, 1, 0);   // underflow wrap
    add(0, 1, 0, 0,  0,    8, 0, 0);
    add(0, 1, 0, 0,  0,    7, 0, 0);
    add(0, 0, 0, 0,  0,    7, 0, 0);   // hold
    add(0, 1, 1, 1, 14,    9, 0, 1);   // clamped load beats en, no evt
    add(0, 1, 1, 0,  0,    0, 1, 0);   // wrap out of loaded max
    add(0, 0, 0, 1,  1,    1, 0, 0);   // load 1
    add(0, 1, 0, 0,  0,    0, 0, 1);   // 1 -> 0 normal step, no evt
    add(0, 0, 1, 1,  7,    7, 0, 0);   // load 7
    add(1, 1, 1, 1,  5,    0, 0, 0);   // reset beats load and en
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 0, 0,   0, 0, 0);   // idle holds 0

    foreach (vecs[i]) begin
      w_rst = vecs[i].rst; w_en = vecs[i].en; w_up = vecs[i].up_dn;
      w_load = vecs[i].load; w_lval = vecs[i].load_val;
      @(posedge clk); #1;
      check($sformatf("wrap[%0d].count", i), int'(w_count), int'(vecs[i].exp_count));
      check($sformatf("wrap[%0d].evt", i),   int'(w_evt),   int'(vecs[i].exp_evt));
      check($sformatf("wrap[%0d].tc", i),    int'(w_tc),    int'(vecs[i].exp_tc));
    end

    // ---- saturate sequence ----
    s_rst = 1; s_en = 0; s_up = 1; s_load = 0; s_lval = 0;
    @(posedge clk); #1;
    check("sat.reset.count", int'(s_count), 0);
    check("sat.reset.evt", int'(s_evt), 0);
    s_rst = 0; s_load = 1; s_lval = 9;
    @(posedge clk); #1;
    check("sat.load9.count", int'(s_count), 9);
    check("sat.load9.evt", int'(s_evt), 0);
    s_load = 0; s_en = 1; s_up = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat.up%0d.count", i), int'(s_count), 9);
      check($sformatf("sat.up%0d.evt", i), int'(s_evt), 1);
      check($sformatf("sat.up%0d.tc", i), int'(s_tc), 1);
    end
    s_up = 0;
    @(posedge clk); #1;
    check("sat.down.count", int'(s_count), 8);
    check("sat.down.evt", int'(s_evt), 0);
    check("sat.down.tc", int'(s_tc), 0);
    s_en = 0; s_load = 1; s_lval = 0;
    @(posedge clk); #1;
    check("sat.load0.count", int'(s_count), 0);
    s_load = 0; s_en = 1; s_up = 0;
    @(posedge clk); #1;
    check("sat.under.count", int'(s_count), 0);
    check("sat.under.evt", int'(s_evt), 1);
    s_en = 0;
    @(posedge clk); #1;
    check("sat.idle.count", int'(s_count), 0);
    check("sat.idle.evt", int'(s_evt), 0);

    // ---- 8-bit cascade ----
    c_rst = 1;
    @(posedge clk); #1;
    check("casc.reset.lo", int'(lo_count), 0);
    check("casc.reset.hi", int'(hi_count), 0);
    c_rst = 0;
    repeat (255) @(posedge clk);
    #1;
    check("casc.255.lo", int'(lo_count), 255);
    check("casc.255.hi", int'(hi_count), 0);
    check("casc.255.lo_tc", int'(lo_tc), 1);
    @(posedge clk); #1;
    check("casc.256.lo", int'(lo_count), 0);
    check("casc.256.lo_evt", int'(lo_evt), 1);
    check("casc.256.hi", int'(hi_count), 1);
    check("casc.256.hi_evt", int'(hi_evt), 0);
    @(posedge clk); #1;
    check("casc.257.lo", int'(lo_count), 1);
    check("casc.257.hi", int'(hi_count), 1);
    check("casc.257.lo_evt", int'(lo_evt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
